// File: rtl/uart_cmd_scheduler_pkg.sv
// Shared codes, state encodings and sensor-frame layout for the UART command scheduler.
package uart_cmd_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BUILD,
        ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        K_STATUS,
        K_TEMP,
        K_HUM
    } kind_t;

    localparam logic [7:0] CMD_STATUS  = 8'h01;
    localparam logic [7:0] CMD_RD_TEMP = 8'h02;
    localparam logic [7:0] CMD_RD_HUM  = 8'h03;
    localparam logic [7:0] CMD_CT_ON   = 8'h04;
    localparam logic [7:0] CMD_CH_ON   = 8'h05;
    localparam logic [7:0] CMD_CT_OFF  = 8'h06;
    localparam logic [7:0] CMD_CH_OFF  = 8'h07;

    localparam logic [7:0] RSP_OK       = 8'h07;
    localparam logic [7:0] RSP_HUM      = 8'h08;
    localparam logic [7:0] RSP_TEMP     = 8'h09;
    localparam logic [7:0] RSP_CTEMP    = 8'h0A;
    localparam logic [7:0] RSP_CHUM     = 8'h0B;
    localparam logic [7:0] RSP_CT_STOP  = 8'h0C;
    localparam logic [7:0] RSP_CH_STOP  = 8'h0D;
    localparam logic [7:0] RSP_FAIL     = 8'h1F;
    localparam logic [7:0] RSP_BAD_ADDR = 8'hEE;
    localparam logic [7:0] RSP_BAD_CMD  = 8'hFF;

    // Sensor frame: {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
    localparam int HUM_INT_LSB = 32;
    localparam int HUM_DEC_LSB = 24;
    localparam int TMP_INT_LSB = 16;
    localparam int TMP_DEC_LSB = 8;
    localparam int CHK_LSB     = 0;

    function automatic logic checksum_ok(input logic [39:0] d);
        logic [7:0] sum;
        sum = d[HUM_INT_LSB +: 8] + d[HUM_DEC_LSB +: 8] + d[TMP_INT_LSB +: 8] + d[TMP_DEC_LSB +: 8];
        return sum == d[CHK_LSB +: 8];
    endfunction

endpackage

// File: rtl/uart_cmd_scheduler_timer.sv
// Loadable down-counter; expire_o pulses on the enabled cycle the count reaches its last step.
module uart_cmd_scheduler_timer #(
    parameter int CYC = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(CYC + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(CYC);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == ONE);

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Turns {cmd,addr} UART words into sensor reads and 2-byte responses, with one
// optional continuous-monitoring session re-issued every PERIOD_CYC.
module uart_cmd_scheduler
    import uart_cmd_scheduler_pkg::*;
#(
    parameter int NUM_SENS    = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int PERIOD_CYC  = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [15:0]       rx_data_i,
    input  logic              rx_valid_i,
    output logic              sens_start_o,
    output logic [ADDR_W-1:0] sens_addr_o,
    input  logic              sens_done_i,
    input  logic              sens_err_i,
    input  logic [39:0]       sens_data_i,
    output logic [15:0]       tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              cmd_drop_o,
    output logic              cont_on_o
);

    localparam logic [8:0] NUM_SENS_W = 9'(NUM_SENS);

    state_t            state_q;
    kind_t             cur_kind_q, cont_kind_q, dec_kind;
    logic              cur_cont_q;
    logic [7:0]        cur_addr_q;
    logic [15:0]       resp_q, tx_data_q, rd_resp, dec_resp;
    logic              sens_start_q, tx_start_q;
    logic [ADDR_W-1:0] sens_addr_q, cont_addr_q;
    logic              cont_on_q, cont_due_q;
    logic              pend_valid_q, pend_valid_d;
    logic [15:0]       pend_data_q, pend_data_d;
    logic              cmd_drop_q, drop_d;

    logic [7:0] cmd_b, addr_b;
    logic       addr_ok, dec_read, dec_cont, dec_off_temp, dec_off_hum;
    logic       take_cmd, take_cont, cont_start_now, cont_off_hit, cont_fail, cont_clear;
    logic       rd_good, rd_fin, timeout_expire, period_expire;

    assign cmd_b   = pend_data_q[15:8];
    assign addr_b  = pend_data_q[7:0];
    assign addr_ok = ({1'b0, addr_b} < NUM_SENS_W);

    always_comb begin
        dec_read     = 1'b0;
        dec_cont     = 1'b0;
        dec_kind     = K_STATUS;
        dec_off_temp = 1'b0;
        dec_off_hum  = 1'b0;
        dec_resp     = {RSP_BAD_CMD, addr_b};
        case (cmd_b)
            CMD_STATUS, CMD_RD_TEMP, CMD_RD_HUM, CMD_CT_ON, CMD_CH_ON: begin
                dec_read = addr_ok;
                dec_resp = {RSP_BAD_ADDR, addr_b};
                dec_cont = addr_ok && (cmd_b == CMD_CT_ON || cmd_b == CMD_CH_ON);
                if (cmd_b == CMD_RD_TEMP || cmd_b == CMD_CT_ON) begin
                    dec_kind = K_TEMP;
                end else if (cmd_b == CMD_RD_HUM || cmd_b == CMD_CH_ON) begin
                    dec_kind = K_HUM;
                end
            end
            CMD_CT_OFF: begin
                dec_off_temp = 1'b1;
                dec_resp     = {RSP_CT_STOP, addr_b};
            end
            CMD_CH_OFF: begin
                dec_off_hum = 1'b1;
                dec_resp    = {RSP_CH_STOP, addr_b};
            end
            default: ;
        endcase
    end

    // The pending command always wins over a due continuous read.
    assign take_cmd       = (state_q == ST_IDLE) && pend_valid_q;
    assign take_cont      = (state_q == ST_IDLE) && !pend_valid_q && cont_due_q;
    assign cont_start_now = take_cmd && dec_cont;
    assign cont_off_hit   = take_cmd && cont_on_q &&
                            ((dec_off_temp && cont_kind_q == K_TEMP) ||
                             (dec_off_hum  && cont_kind_q == K_HUM));

    always_comb begin
        rd_good = sens_done_i && !sens_err_i && checksum_ok(sens_data_i);
        rd_resp = {RSP_FAIL, cur_addr_q};
        if (rd_good) begin
            case (cur_kind_q)
                K_TEMP:  rd_resp = {cur_cont_q ? RSP_CTEMP : RSP_TEMP, sens_data_i[TMP_INT_LSB +: 8]};
                K_HUM:   rd_resp = {cur_cont_q ? RSP_CHUM : RSP_HUM, sens_data_i[HUM_INT_LSB +: 8]};
                default: rd_resp = {RSP_OK, cur_addr_q};
            endcase
        end
    end

    // A sens_done arriving on the timeout cycle still counts as an answer.
    assign rd_fin     = (state_q == ST_WAIT) && (sens_done_i || timeout_expire);
    assign cont_fail  = rd_fin && !rd_good && cur_cont_q;
    assign cont_clear = cont_off_hit || cont_fail;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        drop_d       = 1'b0;
        if (take_cmd) begin
            pend_valid_d = 1'b0;
        end
        if (rx_valid_i) begin
            if (!pend_valid_q || take_cmd) begin
                pend_valid_d = 1'b1;
                pend_data_d  = rx_data_i;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            cmd_drop_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            cmd_drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cur_kind_q   <= K_STATUS;
            cur_cont_q   <= 1'b0;
            cur_addr_q   <= '0;
            resp_q       <= '0;
            sens_start_q <= 1'b0;
            sens_addr_q  <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            cont_on_q    <= 1'b0;
            cont_kind_q  <= K_TEMP;
            cont_addr_q  <= '0;
            cont_due_q   <= 1'b0;
        end else begin
            sens_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_cmd) begin
                        cur_addr_q <= addr_b;
                        cur_kind_q <= dec_kind;
                        cur_cont_q <= dec_cont;
                        if (dec_read) begin
                            sens_start_q <= 1'b1;
                            sens_addr_q  <= addr_b[ADDR_W-1:0];
                            state_q      <= ST_ISSUE;
                        end else begin
                            resp_q  <= dec_resp;
                            state_q <= ST_BUILD;
                        end
                        if (dec_cont) begin
                            cont_on_q   <= 1'b1;
                            cont_kind_q <= dec_kind;
                            cont_addr_q <= addr_b[ADDR_W-1:0];
                            cont_due_q  <= 1'b0;
                        end
                        if (cont_off_hit) begin
                            cont_on_q  <= 1'b0;
                            cont_due_q <= 1'b0;
                        end
                    end else if (take_cont) begin
                        cont_due_q   <= 1'b0;
                        cur_addr_q   <= 8'(cont_addr_q);
                        cur_kind_q   <= cont_kind_q;
                        cur_cont_q   <= 1'b1;
                        sens_start_q <= 1'b1;
                        sens_addr_q  <= cont_addr_q;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (rd_fin) begin
                        resp_q  <= rd_resp;
                        state_q <= ST_BUILD;
                        if (cont_fail) begin
                            cont_on_q  <= 1'b0;
                            cont_due_q <= 1'b0;
                        end
                    end
                end
                ST_BUILD: begin
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= resp_q;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            // Expiry is a single flag, so a missed period never stacks up.
            if (period_expire && !cont_start_now && !cont_clear) begin
                cont_due_q <= 1'b1;
            end
        end
    end

    uart_cmd_scheduler_timer #(.CYC(TIMEOUT_CYC)) u_timeout_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (state_q == ST_ISSUE),
        .en_i     (state_q == ST_WAIT),
        .expire_o (timeout_expire)
    );

    uart_cmd_scheduler_timer #(.CYC(PERIOD_CYC)) u_period_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (cont_start_now || period_expire),
        .en_i     (cont_on_q),
        .expire_o (period_expire)
    );

    assign sens_start_o = sens_start_q;
    assign sens_addr_o  = sens_addr_q;
    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign cmd_drop_o   = cmd_drop_q;
    assign cont_on_o    = cont_on_q;

endmodule
